player_anim_sequencer: RTL and testbench
========================================

# player_anim_sequencer

Animation controller that drives the player sprite address generator. It runs a per-player state machine (stand, run, jump, dead) from game inputs, sequences sprite frames at a fixed rate of vertical-frame ticks, and outputs `animationOffset` and `playerDirection` to the sprite address generator. Outputs change only on frame-tick boundaries, so a sprite is never drawn with a mixed offset within one video frame.

## Interface
- `FRAME_WORDS`, default 1080: ROM words per sprite frame (24×45).
- `TICKS_PER_FRAME`, default 6: frame ticks per animation step, ≥1.
- `STAND_BASE`, default 0: first ROM frame index of STAND (1 frame).
- `RUN_BASE`, default 1, and `RUN_FRAMES`, default 6: RUN frame range; the sequence wraps.
- `JUMP_BASE`, default 7, and `JUMP_FRAMES`, default 4: JUMP frame range; holds on the last frame.
- `DEAD_BASE`, default 11, and `DEAD_FRAMES`, default 3: DEAD frame range; holds on the last frame.

Ports:
- `Clk`, in, 1: system clock.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `frameTick`, in, 1: one-cycle pulse per video frame, asserted at vsync.
- `moveLeft`, in, 1: left movement request (level).
- `moveRight`, in, 1: right movement request (level).
- `jumpReq`, in, 1: jump request (level).
- `onGround`, in, 1: player is standing on a platform.
- `hit`, in, 1: player was struck this frame.
- `respawn`, in, 1: request to respawn after death.
- `animationOffset`, out, 32: ROM word offset, equal to (base + frameIdx) × `FRAME_WORDS`.
- `playerDirection`, out, 1: 0 = right, 1 = left.
- `animState`, out, 2: 0 = STAND, 1 = RUN, 2 = JUMP, 3 = DEAD.
- `deathDone`, out, 1: the death animation has reached its last frame.

## Operation
- Internal registers: `state`, `frameIdx` (width ceil(log2 of the largest frame count)), `tickCnt` (0..`TICKS_PER_FRAME`-1). All of them, and every output, are registered.
- Every register holds its value on any cycle where `frameTick`=0. All of the rules below are evaluated only on cycles where `frameTick`=1.
- Any state change (including re-entry into the same state by respawn) loads `frameIdx`=0 and `tickCnt`=0.
- With no state change, `tickCnt` increments. When it is at `TICKS_PER_FRAME`-1 it wraps to 0 and `frameIdx` advances:
  - RUN: wraps from `RUN_FRAMES`-1 to 0.
  - JUMP and DEAD: saturate at the last frame.
  - STAND: stays at 0.
- Transition priority, highest first:
  1. `hit`=1 while the state is not DEAD: go to DEAD.
  2. DEAD: if `respawn`=1 and `deathDone`=1, go to STAND. Otherwise stay; `respawn` is ignored before `deathDone`.
  3. STAND or RUN with `jumpReq`=1 and `onGround`=1: go to JUMP.
  4. JUMP with `onGround`=1 and `frameIdx`≠0: go to RUN if exactly one move input is set, else go to STAND. Otherwise stay in JUMP.
  5. STAND or RUN: go to RUN if exactly one of `moveLeft`/`moveRight` is set, else go to STAND. A STAND→STAND or RUN→RUN result is not a state change.
- `playerDirection` updates on a tick in every state except DEAD:
  - `moveLeft`=1 and `moveRight`=0: set to 1.
  - `moveRight`=1 and `moveLeft`=0: set to 0.
  - Otherwise it holds.
- `animationOffset` = (BASE(next state) + next `frameIdx`) × `FRAME_WORDS`.
  - Computed with 32-bit unsigned arithmetic.
  - Registered together with `state`.
- `deathDone` = 1 exactly when the next state is DEAD and the next `frameIdx` = `DEAD_FRAMES`-1.

## Timing
- Reset is asynchronous and overrides everything. On reset assertion, in the same instant:
  - `state`=STAND, `frameIdx`=0, `tickCnt`=0.
  - `animationOffset`=`STAND_BASE`×`FRAME_WORDS` (0 with defaults).
  - `playerDirection`=0, `animState`=0, `deathDone`=0.
- Reset asserted mid-animation returns the block to these values; the first tick after release is evaluated from STAND.
- Latency: inputs sampled on a `frameTick` cycle N appear on all outputs at cycle N+1. Outputs are stable until the next tick.
- A move/jump input that is never present on a tick cycle has no effect; there is no latching.
- Frame step rate: one `frameIdx` change per `TICKS_PER_FRAME` ticks. The first advance after entering a state occurs on the `TICKS_PER_FRAME`-th tick after entry.
- Simultaneous events:
  - `hit` together with `jumpReq`: the result is DEAD.
  - `hit` while already in DEAD: ignored.
  - `moveLeft` and `moveRight` both set: treated as no move.
- `TICKS_PER_FRAME`=1: `frameIdx` advances on every tick.

## Test plan
- Reset: drive `Reset_n`=0 asynchronously between clock edges with no clock edge. Required: `animationOffset`=0, `animState`=0, `playerDirection`=0 and `deathDone`=0 immediately.
- Run cycle: hold `moveRight`=1 and issue 40 ticks. Required:
  - `animState`=1 after tick 1.
  - `animationOffset` steps 1080 → 2160 → … → 6480, then wraps to 1080, changing every 6 ticks.
  - `playerDirection`=0 throughout.
- Jump: hold `moveLeft`=1 with `jumpReq`=1 and `onGround`=1 for one tick, then `onGround`=0 for 30 ticks, then `onGround`=1.
  - During the jump: `animState`=2, `playerDirection`=1, and the offset saturates at 10×1080 = 10800.
  - After landing with `moveLeft` still held: `animState`=1 and offset=1080 on the next tick.
- Early landing: jump entered with `onGround` still 1 on the next tick (`frameIdx`=0). Required: the block stays in JUMP until `frameIdx`≠0.
- Death and respawn: pulse `hit` while in RUN, and assert `respawn` from the next tick onward.
  - The offset goes to 11880, then 12960, then 14040.
  - `deathDone`=1 when the offset reaches 14040.
  - Earlier `respawn` is ignored; the block moves to STAND (offset 0) on the tick after `deathDone` rises.
  - `hit` asserted again while in DEAD has no effect.
- Hold between ticks: toggle all inputs every cycle with `frameTick`=0 for 1000 cycles. Required: no output changes.

Source files
------------

// File: rtl/player_anim_sequencer.sv
// Player sprite animation controller: stand/run/jump/dead state machine that
// steps sprite frames on vsync ticks and presents a registered ROM word offset.
module player_anim_sequencer #(
   parameter int unsigned FRAME_WORDS     = 1080,
   parameter int unsigned TICKS_PER_FRAME = 6,
   parameter int unsigned STAND_BASE      = 0,
   parameter int unsigned RUN_BASE        = 1,
   parameter int unsigned RUN_FRAMES      = 6,
   parameter int unsigned JUMP_BASE       = 7,
   parameter int unsigned JUMP_FRAMES     = 4,
   parameter int unsigned DEAD_BASE       = 11,
   parameter int unsigned DEAD_FRAMES     = 3
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frameTick,
   input  logic        moveLeft,
   input  logic        moveRight,
   input  logic        jumpReq,
   input  logic        onGround,
   input  logic        hit,
   input  logic        respawn,
   output logic [31:0] animationOffset,
   output logic        playerDirection,
   output logic [1:0]  animState,
   output logic        deathDone
);

   localparam int unsigned MAX_RJ     = (RUN_FRAMES > JUMP_FRAMES) ? RUN_FRAMES : JUMP_FRAMES;
   localparam int unsigned MAX_FRAMES = (MAX_RJ > DEAD_FRAMES) ? MAX_RJ : DEAD_FRAMES;
   localparam int unsigned IDX_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
   localparam int unsigned TICK_W     = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

   localparam logic [IDX_W-1:0]  RUN_LAST   = IDX_W'(RUN_FRAMES - 1);
   localparam logic [IDX_W-1:0]  JUMP_LAST  = IDX_W'(JUMP_FRAMES - 1);
   localparam logic [IDX_W-1:0]  DEAD_LAST  = IDX_W'(DEAD_FRAMES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_FRAME - 1);
   localparam logic [31:0]       RESET_OFFSET = 32'(STAND_BASE * FRAME_WORDS);

   typedef enum logic [1:0] {
      ST_STAND = 2'd0,
      ST_RUN   = 2'd1,
      ST_JUMP  = 2'd2,
      ST_DEAD  = 2'd3
   } state_t;

   state_t              state, state_n;
   logic [IDX_W-1:0]    frame_idx, frame_idx_n;
   logic [TICK_W-1:0]   tick_cnt, tick_cnt_n;
   logic                direction_n;
   logic                death_done_n;
   logic [31:0]         offset_n;
   logic                one_move;

   function automatic logic [31:0] base_of(input state_t s);
      case (s)
         ST_RUN:  return 32'(RUN_BASE);
         ST_JUMP: return 32'(JUMP_BASE);
         ST_DEAD: return 32'(DEAD_BASE);
         default: return 32'(STAND_BASE);
      endcase
   endfunction

   assign one_move = moveLeft ^ moveRight;

   always_comb begin
      state_n      = state;
      frame_idx_n  = frame_idx;
      tick_cnt_n   = tick_cnt;
      direction_n  = playerDirection;

      // Transition priority: hit, dead/respawn, jump take-off, landing, ground movement
      if (hit && state != ST_DEAD) begin
         state_n = ST_DEAD;
      end else begin
         case (state)
            ST_DEAD: begin
               if (respawn && deathDone) state_n = ST_STAND;
            end
            ST_JUMP: begin
               if (onGround && frame_idx != '0) state_n = one_move ? ST_RUN : ST_STAND;
            end
            default: begin
               if (jumpReq && onGround) state_n = ST_JUMP;
               else                     state_n = one_move ? ST_RUN : ST_STAND;
            end
         endcase
      end

      if (state != ST_DEAD) begin
         if (moveLeft && !moveRight)      direction_n = 1'b1;
         else if (moveRight && !moveLeft) direction_n = 1'b0;
      end

      if (state_n != state) begin
         frame_idx_n = '0;
         tick_cnt_n  = '0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt_n = '0;
         case (state)
            ST_RUN:  frame_idx_n = (frame_idx == RUN_LAST) ? '0 : frame_idx + 1'b1;
            ST_JUMP: frame_idx_n = (frame_idx == JUMP_LAST) ? frame_idx : frame_idx + 1'b1;
            ST_DEAD: frame_idx_n = (frame_idx == DEAD_LAST) ? frame_idx : frame_idx + 1'b1;
            default: frame_idx_n = '0;
         endcase
      end else begin
         tick_cnt_n = tick_cnt + 1'b1;
      end

      offset_n     = (base_of(state_n) + 32'(frame_idx_n)) * 32'(FRAME_WORDS);
      death_done_n = (state_n == ST_DEAD) && (frame_idx_n == DEAD_LAST);
   end

   // Everything, outputs included, moves only on a frame tick so a video frame never sees a partial update
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state           <= ST_STAND;
         frame_idx       <= '0;
         tick_cnt        <= '0;
         animationOffset <= RESET_OFFSET;
         playerDirection <= 1'b0;
         deathDone       <= 1'b0;
      end else if (frameTick) begin
         state           <= state_n;
         frame_idx       <= frame_idx_n;
         tick_cnt        <= tick_cnt_n;
         animationOffset <= offset_n;
         playerDirection <= direction_n;
         deathDone       <= death_done_n;
      end
   end

   assign animState = state;

endmodule

// File: tb/tb_player_anim_sequencer.sv
// Self-checking bench for player_anim_sequencer: directed scenarios plus random
// ticks compared against a tick-counting behavioural model.
module tb_player_anim_sequencer;

   localparam int FW   = 1080;
   localparam int TPF  = 6;
   localparam int RUNF = 6;
   localparam int JMPF = 4;
   localparam int DEDF = 3;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b1;
   logic        frameTick = 1'b0;
   logic        moveLeft = 1'b0, moveRight = 1'b0, jumpReq = 1'b0;
   logic        onGround = 1'b0, hit = 1'b0, respawn = 1'b0;
   logic [31:0] animationOffset;
   logic        playerDirection;
   logic [1:0]  animState;
   logic        deathDone;

   int total = 0;
   int bad   = 0;

   // Model: state 0..3, ticks spent in the state since entry, facing direction
   int m_state = 0;
   int m_cnt   = 0;
   bit m_dir   = 0;

   player_anim_sequencer dut (
      .Clk(Clk), .Reset_n(Reset_n), .frameTick(frameTick),
      .moveLeft(moveLeft), .moveRight(moveRight), .jumpReq(jumpReq),
      .onGround(onGround), .hit(hit), .respawn(respawn),
      .animationOffset(animationOffset), .playerDirection(playerDirection),
      .animState(animState), .deathDone(deathDone)
   );

   always #5 Clk = ~Clk;

   function automatic int model_frame();
      int steps = m_cnt / TPF;
      case (m_state)
         1:       return steps % RUNF;
         2:       return (steps < JMPF - 1) ? steps : JMPF - 1;
         3:       return (steps < DEDF - 1) ? steps : DEDF - 1;
         default: return 0;
      endcase
   endfunction

   function automatic int model_base();
      case (m_state)
         1:       return 1;
         2:       return 7;
         3:       return 11;
         default: return 0;
      endcase
   endfunction

   function automatic logic [35:0] exp_vec();
      logic [31:0] off = 32'((model_base() + model_frame()) * FW);
      logic dd = (m_state == 3) && (model_frame() == DEDF - 1);
      return {2'(m_state), m_dir, dd, off};
   endfunction

   function automatic logic [35:0] got_vec();
      return {animState, playerDirection, deathDone, animationOffset};
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_cnt   = 0;
      m_dir   = 0;
   endtask

   task automatic model_tick(input bit ml, mr, jr, og, h, rs);
      int ns = m_state;
      bit one = ml ^ mr;
      bit dd = (m_state == 3) && (model_frame() == DEDF - 1);
      if (h && m_state != 3)            ns = 3;
      else if (m_state == 3)            begin if (rs && dd) ns = 0; end
      else if (m_state == 2)            begin if (og && model_frame() != 0) ns = one ? 1 : 0; end
      else if (jr && og)                ns = 2;
      else                              ns = one ? 1 : 0;
      if (m_state != 3) begin
         if (ml && !mr)      m_dir = 1;
         else if (mr && !ml) m_dir = 0;
      end
      if (ns != m_state) m_cnt = 0;
      else               m_cnt++;
      m_state = ns;
   endtask

   task automatic applyStimulus(input bit ml, mr, jr, og, h, rs, input bit tick);
      @(negedge Clk);
      moveLeft = ml; moveRight = mr; jumpReq = jr;
      onGround = og; hit = h; respawn = rs;
      frameTick = tick;
      @(posedge Clk);
      #1;
      frameTick = 1'b0;
      if (tick) model_tick(ml, mr, jr, og, h, rs);
   endtask

   task automatic test_reset();
      #2 Reset_n = 1'b0;
      #1;
      if (got_vec() !== 36'h0) begin
         bad++; $display("[TB] FAIL reset_init got=%h want=%h", got_vec(), 36'h0);
      end
      total++;
      @(negedge Clk) Reset_n = 1'b1;
      model_reset();
      // Drive into a non-trivial state, then reset between clock edges
      for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 1, 0, 0, 1);
      applyStimulus(0, 0, 1, 1, 0, 0, 1);
      @(negedge Clk);
      #2 Reset_n = 1'b0;
      #1;
      if (got_vec() !== 36'h0) begin
         bad++; $display("[TB] FAIL reset_mid got=%h want=%h", got_vec(), 36'h0);
      end
      total++;
      @(negedge Clk) Reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_run_cycle();
      for (int t = 1; t <= 40; t++) begin
         applyStimulus(0, 1, 0, 1, 0, 0, 1);
         if (got_vec() !== exp_vec()) begin
            bad++; $display("[TB] FAIL run_tick%0d got=%h want=%h", t, got_vec(), exp_vec());
         end
         total++;
         if (t == 1 || t == 7 || t == 37) begin
            if (animationOffset !== (t == 7 ? 32'd2160 : 32'd1080) || animState !== 2'd1) begin
               bad++; $display("[TB] FAIL run_const%0d got=%0d/%0d want=%0d/1", t,
                               animationOffset, animState, (t == 7 ? 2160 : 1080));
            end
            total++;
         end
      end
   endtask

   task automatic test_jump();
      applyStimulus(1, 0, 1, 1, 0, 0, 1);
      if (got_vec() !== exp_vec() || animState !== 2'd2 || animationOffset !== 32'd7560) begin
         bad++; $display("[TB] FAIL jump_entry got=%h want=%h", got_vec(), exp_vec());
      end
      total++;
      for (int t = 1; t <= 30; t++) begin
         applyStimulus(1, 0, 0, 0, 0, 0, 1);
         if (got_vec() !== exp_vec()) begin
            bad++; $display("[TB] FAIL jump_air%0d got=%h want=%h", t, got_vec(), exp_vec());
         end
         total++;
      end
      if (animationOffset !== 32'd10800 || playerDirection !== 1'b1) begin
         bad++; $display("[TB] FAIL jump_peak got=%0d/%0b want=10800/1", animationOffset, playerDirection);
      end
      total++;
      applyStimulus(1, 0, 0, 1, 0, 0, 1);
      if (animState !== 2'd1 || animationOffset !== 32'd1080 || got_vec() !== exp_vec()) begin
         bad++; $display("[TB] FAIL jump_land got=%h want=%h", got_vec(), exp_vec());
      end
      total++;
   endtask

   task automatic test_early_landing();
      applyStimulus(0, 0, 1, 1, 0, 0, 1);
      for (int t = 1; t <= 7; t++) begin
         applyStimulus(0, 0, 0, 1, 0, 0, 1);
         if (got_vec() !== exp_vec() || animState !== ((t < 7) ? 2'd2 : 2'd0)) begin
            bad++; $display("[TB] FAIL early_land%0d got=%h want=%h", t, got_vec(), exp_vec());
         end
         total++;
      end
   endtask

   task automatic test_death_respawn();
      applyStimulus(0, 1, 0, 1, 0, 0, 1);
      applyStimulus(0, 1, 0, 1, 1, 0, 1);
      if (animationOffset !== 32'd11880 || animState !== 2'd3 || deathDone !== 1'b0) begin
         bad++; $display("[TB] FAIL dead_entry got=%h want=%h", got_vec(), exp_vec());
      end
      total++;
      for (int t = 1; t <= 13; t++) begin
         applyStimulus(1, 0, 1, 1, (t == 3 || t == 9), 1, 1);
         if (got_vec() !== exp_vec()) begin
            bad++; $display("[TB] FAIL dead_tick%0d got=%h want=%h", t, got_vec(), exp_vec());
         end
         total++;
         if (t == 6 && animationOffset !== 32'd12960) begin
            bad++; $display("[TB] FAIL dead_frame1 got=%0d want=12960", animationOffset);
         end
         if (t == 12 && (animationOffset !== 32'd14040 || deathDone !== 1'b1)) begin
            bad++; $display("[TB] FAIL dead_last got=%0d/%0b want=14040/1", animationOffset, deathDone);
         end
         if (t == 13 && (animationOffset !== 32'd0 || animState !== 2'd0 || deathDone !== 1'b0)) begin
            bad++; $display("[TB] FAIL respawn got=%h want=0", got_vec());
         end
         if (t == 6 || t == 12 || t == 13) total++;
      end
   endtask

   task automatic test_hold();
      applyStimulus(0, 1, 0, 1, 0, 0, 1);
      for (int c = 0; c < 1000; c++) begin
         applyStimulus(c[0], ~c[0], c[1], c[0], c[2], 1, 0);
         if (got_vec() !== exp_vec()) begin
            bad++; $display("[TB] FAIL hold_cyc%0d got=%h want=%h", c, got_vec(), exp_vec());
         end
         total++;
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         bit ml = 1'($urandom_range(0, 1));
         bit mr = 1'($urandom_range(0, 1));
         bit jr = ($urandom_range(0, 3) == 0);
         bit og = ($urandom_range(0, 3) != 0);
         bit h  = ($urandom_range(0, 40) == 0);
         bit rs = 1'($urandom_range(0, 1));
         bit tk = ($urandom_range(0, 3) != 0);
         applyStimulus(ml, mr, jr, og, h, rs, tk);
         if (got_vec() !== exp_vec()) begin
            bad++; $display("[TB] FAIL rand%0d got=%h want=%h", n, got_vec(), exp_vec());
         end
         total++;
      end
   endtask

   initial begin
      test_reset();
      test_run_cycle();
      test_jump();
      test_early_landing();
      test_death_respawn();
      test_hold();
      test_random();
      test_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
